// File: rtl/pipe_stage_pkg.sv
// MEM/WB pipeline payload definitions shared by the stage register, its
// handshake interface and the snapshot stack.
package pipe_stage_pkg;

    // Bit positions of each field inside the flat MEM/WB payload.
    localparam int PC_LSB       = 0;
    localparam int PC_MSB       = 31;
    localparam int RD_LSB       = 32;
    localparam int RD_MSB       = 36;
    localparam int ALUOUT_LSB   = 37;
    localparam int ALUOUT_MSB   = 68;
    localparam int DATA_IN_LSB  = 69;
    localparam int DATA_IN_MSB  = 100;
    localparam int WDSEL_LSB    = 101;
    localparam int WDSEL_MSB    = 102;
    localparam int REGWRITE_BIT = 103;

    // The first member is the MSB, so declaration order mirrors the offsets above.
    typedef struct packed {
        logic        reg_write;
        logic [1:0]  wd_sel;
        logic [31:0] data_in;
        logic [31:0] aluout;
        logic [4:0]  rd;
        logic [31:0] pc;
    } mem_wb_t;

    localparam int MEM_WB_W = $bits(mem_wb_t);

    // Reinterpret a flat payload as the structured MEM/WB bundle.
    function automatic mem_wb_t unpack_mem_wb(input logic [MEM_WB_W-1:0] raw);
        return mem_wb_t'(raw);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle around the pipeline stage register.
// slave  : the stage itself (consumes upstream, produces downstream)
// master : the surrounding pipeline (drives upstream, consumes downstream)
interface pipe_stage_reg_if
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = MEM_WB_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg_snap_stack.sv
// LIFO of register snapshots taken on interrupt entry. Push on full and pop on
// empty are ignored here; the owner reports those as overflow/underflow.
module snap_stack
    import pipe_stage_pkg::*;
#(
    parameter int ENTRY_W = MEM_WB_W + 1,
    parameter int DEPTH   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ENTRY_W-1:0]           push_data,
    output logic [ENTRY_W-1:0]           top_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [LVL_W-1:0]   level_q;
    logic [LVL_W-1:0]   level_d;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    // Next stack contents: write at the current level on push, clear the top on pop.
    always_comb begin
        mem_d   = mem_q;
        level_d = level_q;
        if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (level_q == LVL_W'(i)) begin
                    mem_d[i] = push_data;
                end
            end
            level_d = level_q + 1'b1;
        end else if (pop && !empty) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (level_q == LVL_W'(i + 1)) begin
                    mem_d[i] = '0;
                end
            end
            level_d = level_q - 1'b1;
        end
    end

    // Most recent snapshot; zero when empty.
    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LVL_W'(i + 1)) begin
                top_data = mem_q[i];
            end
        end
    end

    // Stack storage and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// MEM/WB pipeline stage register with interrupt snapshot/restore and flush.
// Per-edge priority: int_detected > int_restore > flush > normal transfer.
// Optional build macro PIPE_STAGE_PERF_EN adds saturating stall/bubble
// counters; without it the counter ports read zero and hold no state.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W     = MEM_WB_W,
    parameter int SNAP_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    pipe_stage_reg_if.slave                   bus,
    input  logic                              flush,
    input  logic                              int_detected,
    input  logic                              int_restore,
    output logic [$clog2(SNAP_DEPTH+1)-1:0]   snap_level,
    output logic                              snap_ovf,
    output logic                              snap_unf,
    output logic [CNT_W-1:0]                  stall_cnt,
    output logic [CNT_W-1:0]                  bubble_cnt
);
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              snap_ovf_q,  snap_ovf_d;
    logic              snap_unf_q,  snap_unf_d;

    logic              push, pop;
    logic              stk_full, stk_empty;
    logic [DATA_W:0]   top_entry;

    // Any interrupt or flush activity owns the register this cycle.
    assign bus.in_ready = (!out_valid_q || bus.out_ready)
                          && !int_detected && !int_restore && !flush;

    // Next register state in priority order; a simultaneous restore is dropped.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        snap_ovf_d  = snap_ovf_q;
        snap_unf_d  = snap_unf_q;
        push        = 1'b0;
        pop         = 1'b0;
        if (int_detected) begin
            if (!stk_full) begin
                push = 1'b1;
            end else begin
                snap_ovf_d = 1'b1;
            end
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else if (int_restore) begin
            if (!stk_empty) begin
                pop         = 1'b1;
                out_valid_d = top_entry[DATA_W];
                out_data_d  = top_entry[DATA_W-1:0];
            end else begin
                snap_unf_d = 1'b1;
            end
        end else if (flush) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else if (bus.in_valid && bus.in_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Payload register and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            snap_ovf_q  <= 1'b0;
            snap_unf_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            snap_ovf_q  <= snap_ovf_d;
            snap_unf_q  <= snap_unf_d;
        end
    end

    snap_stack #(
        .ENTRY_W (DATA_W + 1),
        .DEPTH   (SNAP_DEPTH)
    ) u_snap_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data ({out_valid_q, out_data_q}),
        .top_data  (top_entry),
        .level     (snap_level),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign snap_ovf      = snap_ovf_q;
    assign snap_unf      = snap_unf_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counts of held-but-unconsumed and empty cycles.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid_q && !bus.out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (!out_valid_q && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 104, payload width in bits (MEM/WB bundle).
REQ-002 SHALL have parameter SNAP_DEPTH, default 2, interrupt snapshot stack entries (>=1).
REQ-003 SHALL have parameter CNT_W, default 16, performance counter width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  stage accepts payload this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port out_valid  output  1  registered payload valid.
REQ-010 SHALL have port out_ready  input  1  downstream consumes payload.
REQ-011 SHALL have port out_data  output  DATA_W  registered payload.
REQ-012 SHALL have port flush  input  1  discard held payload.
REQ-013 SHALL have port int_detected  input  1  snapshot-and-clear request.
REQ-014 SHALL have port int_restore  input  1  restore-latest-snapshot request.
REQ-015 SHALL have port snap_level  output  $clog2(SNAP_DEPTH+1)  occupied stack entries.
REQ-016 SHALL have port snap_ovf  output  1  sticky push-while-full flag.
REQ-017 SHALL have port snap_unf  output  1  sticky pop-while-empty flag.
REQ-018 SHALL have ports stall_cnt, bubble_cnt  output  CNT_W  performance counters.

Function
REQ-019 Per-edge priority SHALL be: int_detected > int_restore > flush > normal transfer.
REQ-020 in_ready SHALL be combinational: (!out_valid | out_ready) & !int_detected & !int_restore & !flush.
REQ-021 Normal: in_valid & in_ready SHALL load {1, in_data} next edge (latency 1); out_valid & out_ready without load SHALL clear out_valid; otherwise hold.
REQ-022 int_detected with snap_level < SNAP_DEPTH SHALL push {out_valid, out_data}, increment snap_level, and zero out_valid and out_data.
REQ-023 int_detected with snap_level == SNAP_DEPTH SHALL not push, SHALL set snap_ovf, SHALL still zero the register.
REQ-024 int_restore with snap_level > 0 SHALL load top entry into {out_valid, out_data} and decrement snap_level (LIFO, nested interrupts).
REQ-025 int_restore with snap_level == 0 SHALL leave register unchanged and set snap_unf.
REQ-026 Simultaneous int_detected and int_restore SHALL execute only the push; restore is dropped.
REQ-027 flush SHALL zero out_valid and out_data; stack untouched.
REQ-028 snap_ovf and snap_unf SHALL clear only on reset.

Reset
REQ-029 Reset SHALL zero out_valid, out_data, snap_level, snap_ovf, snap_unf, both counters and all stack entries, including mid-interrupt.

Configuration
REQ-030 With PIPE_STAGE_PERF_EN defined, stall_cnt SHALL increment each cycle out_valid & !out_ready, bubble_cnt each cycle !out_valid, both saturating at 2^CNT_W-1.
REQ-031 Without PIPE_STAGE_PERF_EN, counter ports SHALL remain present and tied to 0, with no counter flops.

Structure
REQ-032 Package pipe_stage_pkg SHALL hold MEM/WB field offsets (PC 31:0, rd 36:32, aluout 68:37, data_in 100:69, WDSel 102:101, RegWrite 103), the packed mem_wb_t typedef and default DATA_W.
REQ-033 Snapshot LIFO SHALL be sub-module snap_stack (push, pop, level, full, empty).

Verification
REQ-034 Load 0xA5 with out_ready=0 three cycles -> out_valid=1, out_data=0xA5 held, in_ready=0, stall_cnt=3.
REQ-035 out_data=0x11 valid, int_detected, then int_restore -> zero for one cycle, then out_valid=1, out_data=0x11, snap_level 1->0.
REQ-036 SNAP_DEPTH=2, payloads 0x1,0x2,0x3 each followed by int_detected -> snap_ovf=1, snap_level=2; two restores return 0x2 then 0x1.
REQ-037 int_restore at snap_level 0 -> snap_unf=1, register unchanged; int_detected+int_restore same edge -> push only, snap_level+1.
REQ-038 Reset asserted with snap_level=1 mid-stall -> all outputs 0 asynchronously; subsequent restore sets snap_unf.
